// File: rtl/id_ex_issue_pkg.sv
// Shared CPU definitions: ALU operation codes, MIPS opcode/funct values and the
// issue-register entry layout.
package cpu_defs;
   localparam int DATA_WIDTH = 32;

   localparam logic [2:0] ALUOP_AND  = 3'b000;
   localparam logic [2:0] ALUOP_OR   = 3'b001;
   localparam logic [2:0] ALUOP_ADD  = 3'b010;
   localparam logic [2:0] ALUOP_SLL  = 3'b011;
   localparam logic [2:0] ALUOP_LUI  = 3'b100;
   localparam logic [2:0] ALUOP_SLTU = 3'b101;
   localparam logic [2:0] ALUOP_SUB  = 3'b110;
   localparam logic [2:0] ALUOP_SLT  = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;

   typedef struct packed {
      logic [2:0]            aluop;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [4:0]            dest;
      logic [31:0]           pc;
      logic                  illegal;
   } issue_entry_t;
endpackage

// File: rtl/id_ex_issue_if.sv
// ID -> issue register -> ALU handshake bundle.
interface id_ex_issue_if #(parameter int DW = 32);
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    in_opcode;
   logic [5:0]    in_funct;
   logic [4:0]    in_shamt;
   logic [15:0]   in_imm;
   logic [DW-1:0] in_rs_val;
   logic [DW-1:0] in_rt_val;
   logic [4:0]    in_dest;
   logic [31:0]   in_pc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic [2:0]    out_aluop;
   logic [4:0]    out_dest;
   logic [31:0]   out_pc;
   logic          out_illegal;

   modport slave (
      input  in_valid, in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val,
             in_dest, in_pc, out_ready,
      output in_ready, out_valid, out_a, out_b, out_aluop, out_dest, out_pc, out_illegal
   );

   modport master (
      output in_valid, in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val,
             in_dest, in_pc, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_aluop, out_dest, out_pc, out_illegal
   );
endinterface

// File: rtl/id_ex_issue_decode.sv
// Combinational MIPS opcode/funct decode into ALU operation and operand selection.
module issue_decode
   import cpu_defs::*;
#(
   parameter int DW = 32
) (
   input  logic [5:0]    opcode,
   input  logic [5:0]    funct,
   input  logic [4:0]    shamt,
   input  logic [15:0]   imm,
   input  logic [DW-1:0] rs_val,
   input  logic [DW-1:0] rt_val,
   output logic [2:0]    aluop,
   output logic [DW-1:0] a,
   output logic [DW-1:0] b,
   output logic          illegal
);
   logic [DW-1:0] sext, zext;

   assign sext = {{(DW-16){imm[15]}}, imm};
   assign zext = {{(DW-16){1'b0}}, imm};

   always_comb begin
      aluop   = ALUOP_AND;
      a       = '0;
      b       = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            a = rs_val;
            b = rt_val;
            case (funct)
               FUNCT_ADDU: aluop = ALUOP_ADD;
               FUNCT_SUBU: aluop = ALUOP_SUB;
               FUNCT_AND:  aluop = ALUOP_AND;
               FUNCT_OR:   aluop = ALUOP_OR;
               FUNCT_SLT:  aluop = ALUOP_SLT;
               FUNCT_SLTU: aluop = ALUOP_SLTU;
               FUNCT_SLL: begin
                  aluop = ALUOP_SLL;
                  a     = {{(DW-5){1'b0}}, shamt};
               end
               default: begin
                  a       = '0;
                  b       = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_ADDIU, OP_LW, OP_SW: begin
            aluop = ALUOP_ADD;
            a     = rs_val;
            b     = sext;
         end
         OP_SLTI: begin
            aluop = ALUOP_SLT;
            a     = rs_val;
            b     = sext;
         end
         OP_SLTIU: begin
            aluop = ALUOP_SLTU;
            a     = rs_val;
            b     = sext;
         end
         OP_ANDI: begin
            aluop = ALUOP_AND;
            a     = rs_val;
            b     = zext;
         end
         OP_ORI: begin
            aluop = ALUOP_OR;
            a     = rs_val;
            b     = zext;
         end
         // ALU shifts B left by 16; A is unused and forced to zero.
         OP_LUI: begin
            aluop = ALUOP_LUI;
            b     = zext;
         end
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/id_ex_issue.sv
// EX issue register: decodes ID fields and holds ALU operands behind a
// valid/ready handshake with a one-entry skid so ID never sees out_ready.
module id_ex_issue
   import cpu_defs::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   id_ex_issue_if.slave         io,
   output logic [CNT_WIDTH-1:0] issue_cnt
);
   issue_entry_t          dec, main_q, skid_q;
   logic                  main_vld, skid_vld;
   logic                  accept, issue;
   logic [2:0]            dec_aluop;
   logic [DATA_WIDTH-1:0] dec_a, dec_b;
   logic                  dec_ill;

   issue_decode #(.DW(DATA_WIDTH)) u_decode (
      .opcode  (io.in_opcode),
      .funct   (io.in_funct),
      .shamt   (io.in_shamt),
      .imm     (io.in_imm),
      .rs_val  (io.in_rs_val),
      .rt_val  (io.in_rt_val),
      .aluop   (dec_aluop),
      .a       (dec_a),
      .b       (dec_b),
      .illegal (dec_ill)
   );

   assign dec = '{aluop: dec_aluop, a: dec_a, b: dec_b, dest: io.in_dest,
                  pc: io.in_pc, illegal: dec_ill};

   // in_ready comes straight from the skid flop, so it never depends on out_ready.
   assign io.in_ready = ~skid_vld;
   assign accept      = io.in_valid & ~skid_vld;
   assign issue       = main_vld & io.out_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_vld  <= 1'b0;
         skid_vld  <= 1'b0;
         main_q    <= '0;
         skid_q    <= '0;
         issue_cnt <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         if (issue)
            issue_cnt <= issue_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         if (!main_vld || issue) begin
            if (skid_vld) begin
               // Older skid entry moves up first; a new accept backfills the skid.
               main_q   <= skid_q;
               main_vld <= 1'b1;
               skid_vld <= accept;
               if (accept)
                  skid_q <= dec;
            end else begin
               main_vld <= accept;
               if (accept)
                  main_q <= dec;
            end
         end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
         end
      end
   end

   assign io.out_valid   = main_vld;
   assign io.out_a       = main_q.a;
   assign io.out_b       = main_q.b;
   assign io.out_aluop   = main_q.aluop;
   assign io.out_dest    = main_q.dest;
   assign io.out_pc      = main_q.pc;
   assign io.out_illegal = main_q.illegal;
endmodule
